uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance among NUM_REQ byte producers (debug log, status reporter, command echo, ...).
- Round-robin arbitration with a valid/ready byte handshake per requester.
- Drives the transmitter's pi_data/pi_flag pair.
- The transmitter has no busy/done output, so the block owns frame pacing: it waits a guard interval derived from CLK/BPS before issuing the next byte.

Parameters:
- CLK, 100_000_000, system clock frequency in Hz.
- BPS, 9600, baud rate; must equal the uart_tx setting.
- NUM_REQ, 4, number of requesters, 2..8.
- GUARD_BITS, 11, frame guard length in bit periods: 10 frame bits plus 1 margin for the transmitter's start/stop skew.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, NUM_REQ, per-requester byte available.
- req_data, in, 8*NUM_REQ, byte for requester i at [8i+7:8i].
- req_last, in, NUM_REQ, byte is last of a packet (used only with the optional feature).
- req_ready, out, NUM_REQ, byte accepted; one-hot or zero.
- tx_byte, out, 8, to uart_tx pi_data.
- tx_flag, out, 1, to uart_tx pi_flag; single-cycle pulse.
- busy, out, 1, high in SEND and WAIT.
- grant_id, out, clog2(NUM_REQ) with minimum width 1, index of the last granted requester.

Behaviour:
Constants:
- BAUD_CNT_MAX = CLK/BPS (integer division).
- FRAME_CYCLES = BAUD_CNT_MAX*GUARD_BITS.
- Guard counter width = clog2(FRAME_CYCLES)+1.

Reset values:
- FSM IDLE, all outputs 0, rr pointer 0.
- Reset mid-frame aborts pacing immediately. The uart_tx is reset by the same rst_n.

FSM states IDLE, SEND, WAIT.
- IDLE:
  - Search req_valid starting at the rr pointer, wrapping modulo NUM_REQ.
  - On a hit g, req_ready[g] = 1 combinationally in the same cycle. The handshake is req_valid[g] & req_ready[g].
  - At the clock edge, latch req_data[g] into tx_byte, set grant_id = g, and go to SEND.
  - No valid requester: stay in IDLE, req_ready = 0.
- SEND:
  - tx_flag = 1 for exactly this cycle.
  - Load the guard counter with FRAME_CYCLES-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - On reaching 0, go to IDLE and set the rr pointer to grant_id+1, wrapping from NUM_REQ-1 to 0.
- req_ready is 0 outside IDLE. A requester must hold valid and data stable until its handshake.

Timing:
- Latency from handshake (cycle T) to tx_flag high is exactly 1 cycle (T+1).
- tx_byte is stable from T+1 until the next handshake.
- Consecutive tx_flag pulses are spaced exactly FRAME_CYCLES+2 cycles apart under continuous demand.

Boundary cases:
- All requesters valid: strict rotation 0,1,2,3,0,...
- Only one requester valid: it is granted every frame.
- A valid that drops while the FSM is not in IDLE is not an error; no byte is taken.
- A requester that asserts valid in the same cycle the FSM enters IDLE is eligible in that cycle.

Optional Feature:
UART_ARB_PKT_LOCK_EN
- Defined:
  - After a handshake with req_last[g] = 0, the grant is locked to g.
  - In IDLE, only req_valid[g] is considered; other requesters wait even if valid.
  - The lock clears on a handshake with req_last[g] = 1.
  - The rr pointer advances to g+1 only when the lock clears.
  - While locked, the FSM stays in IDLE indefinitely until g supplies its next byte, so packets are never interleaved on the line.
- Undefined:
  - req_last is ignored and arbitration is per byte.
  - The lock register does not exist.

Decomposition:
- Shared package uart_pkg:
  - function baud_cnt_max(CLK, BPS).
  - localparam FRAME_BITS = 10.
  - FSM state typedef {IDLE, SEND, WAIT}.
- One sub-module: rr_arbiter. Inputs are the request vector and pointer (plus lock/locked id when enabled); outputs are the one-hot grant and the encoded index.
- A top-level wrapper uart_tx_mux instantiates uart_tx_arbiter and uart_tx; it is outside this block's scope.

Test Plan:
- Bench configuration: CLK=1000, BPS=100, NUM_REQ=4, so BAUD_CNT_MAX=10 and FRAME_CYCLES=110.
- Reset with requests already pending -> outputs 0; first handshake occurs on the first cycle after rst_n deasserts, to requester 0.
- All 4 requesters continuously valid with data 0x10,0x21,0x32,0x43 -> grant order 0,1,2,3,0; tx_flag pulses 112 cycles apart. The uart_tx line decodes exactly those bytes with no framing error.
- Only requester 2 valid with 0xA5 -> handshake, tx_flag 1 cycle later with tx_byte=0xA5, busy for 111 cycles, then immediate re-grant to 2.
- rst_n pulsed mid-WAIT (counter at about 50) -> FSM IDLE, tx_flag 0, rr pointer 0, tx line idle high; the next request is served normally.
- With UART_ARB_PKT_LOCK_EN: requester 1 sends 3 bytes with last on the 3rd while requester 0 stays valid -> line carries all 3 bytes of requester 1 before any byte of requester 0.
- Without UART_ARB_PKT_LOCK_EN, same stimulus -> bytes alternate between requesters 1 and 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: frame constants, FSM state type
// and the baud-divider helper.
package uart_pkg;

    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    function automatic int baud_cnt_max(input int clk_hz, input int bps);
        return clk_hz / bps;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Per-requester byte handshake bus between the producers (master) and the
// transmit arbiter (slave).
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;

    modport master (output req_valid, output req_data, output req_last, input req_ready);
    modport slave  (input req_valid, input req_data, input req_last, output req_ready);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin search over the request vector starting at ptr. With
// UART_ARB_PKT_LOCK_EN, an active lock restricts eligibility to lock_id.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
`ifdef UART_ARB_PKT_LOCK_EN
    input  logic               lock,
    input  logic [ID_W-1:0]    lock_id,
`endif
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               hit
);

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] req_m;

`ifdef UART_ARB_PKT_LOCK_EN
    assign elig = lock ? (NUM_REQ'(1) << lock_id) : '1;
`else
    assign elig = '1;
`endif
    assign req_m = req & elig;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        hit       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!hit && req_m[j]) begin
                hit       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ byte producers with round-robin grants and
// frame pacing. Optional packet lock: define UART_ARB_PKT_LOCK_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int CLK        = 100_000_000,
    parameter int BPS        = 9600,
    parameter int NUM_REQ    = 4,
    parameter int GUARD_BITS = FRAME_BITS + 1,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave req,
    output logic [7:0]       tx_byte,
    output logic             tx_flag,
    output logic             busy,
    output logic [ID_W-1:0]  grant_id
);

    localparam int BAUD_CNT_MAX = baud_cnt_max(CLK, BPS);
    localparam int FRAME_CYCLES = BAUD_CNT_MAX * GUARD_BITS;
    localparam int CNT_W        = $clog2(FRAME_CYCLES) + 1;
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(FRAME_CYCLES - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ID_W-1:0]    ptr, ptr_nxt;
    logic [7:0]         byte_nxt;
    logic [ID_W-1:0]    gid_nxt;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               hit;
    logic [ID_W-1:0]    ptr_after;

    assign ptr_after = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef UART_ARB_PKT_LOCK_EN
    logic locked, locked_nxt;
`else
    logic unused_last;
    assign unused_last = ^req.req_last;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req.req_valid),
        .ptr       (ptr),
`ifdef UART_ARB_PKT_LOCK_EN
        .lock      (locked),
        .lock_id   (grant_id),
`endif
        .grant     (grant),
        .grant_idx (grant_idx),
        .hit       (hit)
    );

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        ptr_nxt       = ptr;
        byte_nxt      = tx_byte;
        gid_nxt       = grant_id;
        req.req_ready = '0;
        tx_flag       = 1'b0;
        busy          = 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
        locked_nxt    = locked;
`endif
        unique case (state)
            IDLE: begin
                // Gate with rst_n so no requester sees ready while reset is held.
                req.req_ready = grant & {NUM_REQ{rst_n}};
                if (hit) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant[i]) byte_nxt = req.req_data[8*i +: 8];
                    end
                    gid_nxt   = grant_idx;
                    state_nxt = SEND;
`ifdef UART_ARB_PKT_LOCK_EN
                    locked_nxt = ~|(grant & req.req_last);
`endif
                end
            end
            SEND: begin
                tx_flag   = 1'b1;
                busy      = 1'b1;
                cnt_nxt   = GUARD_LOAD;
                state_nxt = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_nxt = IDLE;
`ifdef UART_ARB_PKT_LOCK_EN
                    if (!locked) ptr_nxt = ptr_after;
`else
                    ptr_nxt = ptr_after;
`endif
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ptr      <= '0;
            tx_byte  <= '0;
            grant_id <= '0;
`ifdef UART_ARB_PKT_LOCK_EN
            locked   <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ptr      <= ptr_nxt;
            tx_byte  <= byte_nxt;
            grant_id <= gid_nxt;
`ifdef UART_ARB_PKT_LOCK_EN
            locked   <= locked_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a transaction-level
// model of grants, frame timing and the optional packet lock.
module tb_uart_tx_arbiter;

    localparam int N      = 4;
    localparam int FRAME  = 110;
    localparam int PERIOD = FRAME + 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_byte;
    logic       tx_flag;
    logic       busy;
    logic [1:0] grant_id;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(
        .CLK        (1000),
        .BPS        (100),
        .NUM_REQ    (N),
        .GUARD_BITS (11)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (bus),
        .tx_byte  (tx_byte),
        .tx_flag  (tx_flag),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Producer FIFOs of {last, data}
    logic [8:0] fifo [N][64];
    int         rd [N];
    int         wr [N];
    bit         refill [N];
    logic [7:0] refill_byte [N];
    bit         rand_mode;
    bit         rst_req;

    // Reference model state
    int         cyc, hs_cyc, free_at, m_ptr, lock_id, m_gid;
    bit         locked;
    logic [7:0] m_byte;

    // Handshakes and flags observed on the DUT
    int dut_hs_id [$];
    int dut_hs_cyc [$];
    int dut_flag_cyc [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int i, input logic [8:0] e);
        fifo[i][wr[i] % 64] = e;
        wr[i]++;
    endtask

    function automatic bit pending(input int i);
        return rd[i] != wr[i];
    endfunction

    task automatic clear_fifos();
        for (int i = 0; i < N; i++) begin
            rd[i]     = wr[i];
            refill[i] = 1'b0;
        end
    endtask

    task automatic step();
        int               w;
        logic [N-1:0]     v, l, exp_ready;
        logic [8*N-1:0]   d;
        logic [8:0]       h;
        @(negedge clk);
        rst_n = rst_req;
        for (int i = 0; i < N; i++) begin
            if (!pending(i)) begin
                if (refill[i]) push(i, {1'b1, refill_byte[i]});
                else if (rand_mode && $urandom_range(3) == 0) push(i, 9'($urandom));
            end else if (rand_mode && cyc > hs_cyc && cyc < free_at && $urandom_range(63) == 0) begin
                rd[i]++;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (pending(i)) begin
                h = fifo[i][rd[i] % 64];
                v[i] = 1'b1;
                l[i] = h[8];
                d[8*i +: 8] = h[7:0];
            end else begin
                v[i] = 1'b0;
                l[i] = 1'($urandom);
                d[8*i +: 8] = 8'($urandom);
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
        #1;
        w = -1;
        if (!rst_n) begin
            hs_cyc  = -1000;
            free_at = 0;
            m_ptr   = 0;
            locked  = 1'b0;
            lock_id = 0;
            m_byte  = 8'h00;
            m_gid   = 0;
        end else if (cyc >= free_at) begin
            if (locked) begin
                if (pending(lock_id)) w = lock_id;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && pending((m_ptr + k) % N)) w = (m_ptr + k) % N;
                end
            end
        end
        exp_ready = (w >= 0) ? (N'(1) << w) : '0;
        check("req_ready", bus.req_ready, exp_ready);
        check("tx_flag", tx_flag, rst_n && cyc == hs_cyc + 1);
        check("busy", busy, rst_n && cyc > hs_cyc && cyc < free_at);
        check("tx_byte", tx_byte, m_byte);
        check("grant_id", grant_id, m_gid);
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    dut_hs_id.push_back(i);
                    dut_hs_cyc.push_back(cyc);
                end
            end
        end
        if (tx_flag) dut_flag_cyc.push_back(cyc);
        if (w >= 0) begin
            h = fifo[w][rd[w] % 64];
            rd[w]++;
            m_byte  = h[7:0];
            m_gid   = w;
            hs_cyc  = cyc;
            free_at = cyc + PERIOD;
`ifdef UART_ARB_PKT_LOCK_EN
            if (!h[8]) begin
                locked  = 1'b1;
                lock_id = w;
            end else begin
                locked = 1'b0;
                m_ptr  = (w + 1) % N;
            end
`else
            m_ptr = (w + 1) % N;
`endif
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic sync_busy(input int offset);
        for (int k = 0; k < 400 && cyc != hs_cyc + offset; k++) step();
        check("sync_timeout", cyc == hs_cyc + offset, 1'b1);
    endtask

    initial begin
        int p1_rel, base, rel3;
        int exp4 [4];
        cyc = 0; hs_cyc = -1000; free_at = 0; m_ptr = 0; lock_id = 0; m_gid = 0;
        locked = 1'b0; m_byte = 8'h00; rand_mode = 1'b0; rst_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            rd[i] = 0; wr[i] = 0; refill[i] = 1'b1;
        end
        refill_byte[0] = 8'h10; refill_byte[1] = 8'h21;
        refill_byte[2] = 8'h32; refill_byte[3] = 8'h43;
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;

        // Reset with all requesters pending, then strict rotation
        run(4);
        rst_req = 1'b1;
        p1_rel  = cyc;
        run(5 * PERIOD + 2);
        check("p1_hs_count", dut_hs_id.size() >= 5, 1'b1);
        check("p1_first_hs", dut_hs_cyc[0], p1_rel);
        check("p1_first_flag", dut_flag_cyc[0], p1_rel + 1);
        for (int k = 0; k < 5; k++) check("p1_order", dut_hs_id[k], k % 4);
        for (int k = 1; k < 5; k++) check("p1_flag_gap", dut_flag_cyc[k] - dut_flag_cyc[k-1], PERIOD);

        // Only requester 2 valid
        sync_busy(5);
        clear_fifos();
        refill[2] = 1'b1; refill_byte[2] = 8'hA5;
        base = dut_hs_id.size();
        run(4 * PERIOD);
        check("p2_hs_count", dut_hs_id.size() >= base + 3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check("p2_id", dut_hs_id[base + k], 2);
            check("p2_gap", dut_hs_cyc[base + k] - dut_hs_cyc[base + k - 1], PERIOD);
        end

        // Reset in the middle of the guard wait
        sync_busy(60);
        clear_fifos();
        rst_req = 1'b0;
        run(3);
        rst_req = 1'b1;
        push(0, {1'b1, 8'h5C});
        base = dut_hs_id.size();
        rel3 = cyc;
        run(PERIOD + 3);
        check("p3_hs_count", dut_hs_id.size(), base + 1);
        check("p3_id", dut_hs_id[base], 0);
        check("p3_hs_cyc", dut_hs_cyc[base], rel3);

        // Three-byte packet from requester 1 against a continuously valid requester 0
        refill[0] = 1'b1; refill_byte[0] = 8'h0F;
        push(1, {1'b0, 8'hB0});
        push(1, {1'b0, 8'hB1});
        push(1, {1'b1, 8'hB2});
`ifdef UART_ARB_PKT_LOCK_EN
        exp4 = '{1, 1, 1, 0};
`else
        exp4 = '{1, 0, 1, 0};
`endif
        base = dut_hs_id.size();
        run(5 * PERIOD);
        check("p4_hs_count", dut_hs_id.size() >= base + 4, 1'b1);
        for (int k = 0; k < 4; k++) check("p4_order", dut_hs_id[base + k], exp4[k]);

        // Random traffic with random packet boundaries and withdrawals while busy
        sync_busy(5);
        clear_fifos();
        rand_mode = 1'b1;
        run(25 * PERIOD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
